// File: rtl/cu_pkg.sv
// Shared opcode encoding and instruction field layout for the control unit.
package cu_pkg;
    localparam int OPW   = 4;
    localparam int REGW  = 3;
    localparam int ADRW  = 4;
    localparam int INSTW = 13;

    localparam int OP_LSB  = 9;
    localparam int RA_LSB  = 6;
    localparam int RB_LSB  = 3;
    localparam int RD_LSB  = 0;
    localparam int ADR_LSB = 5;

    typedef enum logic [OPW-1:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_NOT   = 4'h6,
        OP_SHL   = 4'h7,
        OP_SHR   = 4'h8,
        OP_MUL   = 4'h9,
        OP_LOAD  = 4'hE,
        OP_STORE = 4'hF
    } opcode_e;
endpackage

// File: rtl/cu_decode.sv
// Purely combinational instruction decode: splits the word into fields and strobes.
module cu_decode
    import cu_pkg::*;
(
    input  logic [INSTW-1:0] instIn,
    output logic [OPW-1:0]   opcode,
    output logic [ADRW-1:0]  adrr,
    output logic [REGW-1:0]  operanda,
    output logic [REGW-1:0]  operandb,
    output logic [REGW-1:0]  dest,
    output logic [OPW-1:0]   alu_op,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             illegal
);
    always_comb begin
        opcode   = instIn[OP_LSB +: OPW];
        adrr     = '0;
        operanda = '0;
        operandb = '0;
        dest     = '0;
        alu_op   = '0;
        reg_we   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        illegal  = 1'b0;
        if (opcode >= OP_ADD && opcode <= OP_MUL) begin
            operanda = instIn[RA_LSB +: REGW];
            operandb = instIn[RB_LSB +: REGW];
            dest     = instIn[RD_LSB +: REGW];
            alu_op   = opcode;
            reg_we   = 1'b1;
        end else if (opcode == OP_LOAD) begin
            adrr   = instIn[ADR_LSB +: ADRW];
            dest   = instIn[RD_LSB +: REGW];
            mem_rd = 1'b1;
            reg_we = 1'b1;
        end else if (opcode == OP_STORE) begin
            // dest carries the register whose contents are written to memory
            adrr   = instIn[ADR_LSB +: ADRW];
            dest   = instIn[RD_LSB +: REGW];
            mem_wr = 1'b1;
        end else if (opcode != OP_NOP) begin
            illegal = 1'b1;
        end
    end
endmodule

// File: rtl/cu.sv
// Control unit: one-cycle registered decode with hold freeze and async reset.
module cu
    import cu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [INSTW-1:0] instIn,
    input  logic             inst_valid,
    input  logic             hold,
    output logic [OPW-1:0]   opcode,
    output logic [ADRW-1:0]  adrr,
    output logic [REGW-1:0]  operanda,
    output logic [REGW-1:0]  operandb,
    output logic [REGW-1:0]  dest,
    output logic [OPW-1:0]   alu_op,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             illegal,
    output logic             out_valid
);
    logic [OPW-1:0]  d_opcode;
    logic [ADRW-1:0] d_adrr;
    logic [REGW-1:0] d_operanda;
    logic [REGW-1:0] d_operandb;
    logic [REGW-1:0] d_dest;
    logic [OPW-1:0]  d_alu_op;
    logic            d_reg_we;
    logic            d_mem_rd;
    logic            d_mem_wr;
    logic            d_illegal;

    cu_decode u_decode (
        .instIn   (instIn),
        .opcode   (d_opcode),
        .adrr     (d_adrr),
        .operanda (d_operanda),
        .operandb (d_operandb),
        .dest     (d_dest),
        .alu_op   (d_alu_op),
        .reg_we   (d_reg_we),
        .mem_rd   (d_mem_rd),
        .mem_wr   (d_mem_wr),
        .illegal  (d_illegal)
    );

    // Decode -> output register stage; idle cycles drop strobes but keep fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode    <= '0;
            adrr      <= '0;
            operanda  <= '0;
            operandb  <= '0;
            dest      <= '0;
            alu_op    <= '0;
            reg_we    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!hold) begin
            if (inst_valid) begin
                opcode    <= d_opcode;
                adrr      <= d_adrr;
                operanda  <= d_operanda;
                operandb  <= d_operandb;
                dest      <= d_dest;
                alu_op    <= d_alu_op;
                reg_we    <= d_reg_we;
                mem_rd    <= d_mem_rd;
                mem_wr    <= d_mem_wr;
                illegal   <= d_illegal;
                out_valid <= 1'b1;
            end else begin
                reg_we    <= 1'b0;
                mem_rd    <= 1'b0;
                mem_wr    <= 1'b0;
                illegal   <= 1'b0;
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cu.sv
// Scoreboard bench for cu: stimulus queues expected outputs, a monitor compares them.
module tb_cu;
    logic        clk;
    logic        rst;
    logic [12:0] instIn;
    logic        inst_valid;
    logic        hold;
    logic [3:0]  opcode;
    logic [3:0]  adrr;
    logic [2:0]  operanda;
    logic [2:0]  operandb;
    logic [2:0]  dest;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
    logic        out_valid;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] adr;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] d;
        logic [3:0] alu;
        logic       we;
        logic       rd;
        logic       wr;
        logic       ill;
        logic       vld;
    } out_t;

    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    cu dut (
        .clk        (clk),
        .rst        (rst),
        .instIn     (instIn),
        .inst_valid (inst_valid),
        .hold       (hold),
        .opcode     (opcode),
        .adrr       (adrr),
        .operanda   (operanda),
        .operandb   (operandb),
        .dest       (dest),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .illegal    (illegal),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t cur();
        return {opcode, adrr, operanda, operandb, dest, alu_op,
                reg_we, mem_rd, mem_wr, illegal, out_valid};
    endfunction

    function automatic out_t mk(input logic [3:0] op, input logic [3:0] adr,
                                input logic [2:0] a, input logic [2:0] b,
                                input logic [2:0] d, input logic [3:0] alu,
                                input logic we, input logic rd, input logic wr,
                                input logic ill, input logic vld);
        return {op, adr, a, b, d, alu, we, rd, wr, ill, vld};
    endfunction

    task automatic check_now(input string nm, input out_t e);
        out_t g;
        g = cur();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, g, e);
        end
    endtask

    // Drive one cycle of input, then queue what the registers must hold after that edge
    task automatic step(input logic [12:0] ins, input logic v, input logic h,
                        input out_t e, input string nm);
        @(negedge clk);
        instIn     = ins;
        inst_valid = v;
        hold       = h;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            out_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check_now(nm, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        instIn     = '0;
        inst_valid = 1'b0;
        hold       = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_now("reset_async", '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        step(13'b0001_001_010_011, 1, 0, mk(4'h1, 4'h0, 3'd1, 3'd2, 3'd3, 4'h1, 1, 0, 0, 0, 1), "add");
        step(13'b1111_1100_00_101, 1, 0, mk(4'hF, 4'hC, 3'd0, 3'd0, 3'd5, 4'h0, 0, 0, 1, 0, 1), "store");
        step(13'b1110_0100_00_100, 1, 0, mk(4'hE, 4'h4, 3'd0, 3'd0, 3'd4, 4'h0, 1, 1, 0, 0, 1), "load");
        step(13'b0011_001_011_100, 1, 0, mk(4'h3, 4'h0, 3'd1, 3'd3, 3'd4, 4'h3, 1, 0, 0, 0, 1), "b2b_and");
        step(13'b1001_011_111_000, 1, 0, mk(4'h9, 4'h0, 3'd3, 3'd7, 3'd0, 4'h9, 1, 0, 0, 0, 1), "b2b_mul");
        step(13'b0001_111_111_111, 0, 0, mk(4'h9, 4'h0, 3'd3, 3'd7, 3'd0, 4'h9, 0, 0, 0, 0, 0), "idle_keep_fields");
        step(13'b1011_000000000,   1, 0, mk(4'hB, 4'h0, 3'd0, 3'd0, 3'd0, 4'h0, 0, 0, 0, 1, 1), "illegal_b");
        step(13'b0001_001_010_011, 1, 1, mk(4'hB, 4'h0, 3'd0, 3'd0, 3'd0, 4'h0, 0, 0, 0, 1, 1), "hold_valid");
        step(13'b1110_0100_00_100, 0, 1, mk(4'hB, 4'h0, 3'd0, 3'd0, 3'd0, 4'h0, 0, 0, 0, 1, 1), "hold_idle");
        step(13'b0111_111_000_110, 1, 0, mk(4'h7, 4'h0, 3'd7, 3'd0, 3'd6, 4'h7, 1, 0, 0, 0, 1), "shl");
        step(13'b1101_111_111_111, 1, 0, mk(4'hD, 4'h0, 3'd0, 3'd0, 3'd0, 4'h0, 0, 0, 0, 1, 1), "illegal_d");
        step(13'b0110_101_010_001, 1, 0, mk(4'h6, 4'h0, 3'd5, 3'd2, 3'd1, 4'h6, 1, 0, 0, 0, 1), "not");
        step(13'b0001_001_010_011, 1, 0, mk(4'h1, 4'h0, 3'd1, 3'd2, 3'd3, 4'h1, 1, 0, 0, 0, 1), "add_pre_rst");

        // Mid-cycle reset with a store still presented at the input
        @(negedge clk);
        instIn     = 13'b1111_1100_00_101;
        inst_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_now("reset_mid", '0);
        #1 rst = 1'b0;
        inst_valid = 1'b0;

        step(13'b0000_000000000, 1, 0, mk(4'h0, 4'h0, 3'd0, 3'd0, 3'd0, 4'h0, 0, 0, 0, 0, 1), "nop_after_rst");
        step(13'b1000_010_001_111, 1, 0, mk(4'h8, 4'h0, 3'd2, 3'd1, 3'd7, 4'h8, 1, 0, 0, 0, 1), "shr");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cu.md
CU -- requirements
Module: cu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock, sampled on every edge.
REQ-002 The reset port SHALL be: rst  input  1  asynchronous, active-high reset.
REQ-003 instIn  input  13  instruction word; decoded only when inst_valid=1.
REQ-004 inst_valid  input  1  instIn holds a new instruction this cycle.
REQ-005 hold  input  1  freezes all outputs while high; has priority over inst_valid.
REQ-006 opcode  output  4  registered opcode field.
REQ-007 adrr  output  4  registered data-memory address; memory opcodes only.
REQ-008 operanda  output  3  registered source register A.
REQ-009 operandb  output  3  registered source register B.
REQ-010 dest  output  3  registered destination register; for STORE it is the source data register.
REQ-011 alu_op  output  4  registered ALU function code, equal to the opcode for ALU instructions and 0 otherwise.
REQ-012 The decode strobes SHALL be: reg_we, mem_rd, mem_wr, illegal, out_valid, each an output of width 1.

Function
REQ-013 The instruction format SHALL be: opcode=instIn[12:9]; R-type operanda=[8:6], operandb=[5:3], dest=[2:0]; M-type (1110, 1111) adrr=[8:5], [4:3] ignored, dest=[2:0].
REQ-014 The opcode map SHALL be: 0000 NOP; 0001 ADD; 0010 SUB; 0011 AND; 0100 OR; 0101 XOR; 0110 NOT (operandb ignored); 0111 SHL; 1000 SHR; 1001 MUL; 1010-1101 illegal; 1110 LOAD; 1111 STORE.
REQ-015 The latency SHALL be exactly 1 cycle: with hold=0 and inst_valid=1 at edge N, the decoded outputs and out_valid=1 appear after edge N.
REQ-016 R-type (0001-1001): reg_we=1, mem_rd=0, mem_wr=0, adrr=0, alu_op=opcode, and operanda, operandb and dest taken from their fields.
REQ-017 LOAD: mem_rd=1, reg_we=1, mem_wr=0, operanda=0, operandb=0, alu_op=0, adrr and dest taken from their fields.
REQ-018 STORE: mem_wr=1, reg_we=0, mem_rd=0, operanda=0, operandb=0, alu_op=0, adrr and dest taken from their fields.
REQ-019 NOP: opcode=0000, every strobe 0 except out_valid=1, and all field outputs 0.
REQ-020 Illegal opcode: illegal=1, reg_we=0, mem_rd=0, mem_wr=0, opcode passed through, all field outputs 0.
REQ-021 With hold=0 and inst_valid=0 at an edge: out_valid, reg_we, mem_rd, mem_wr and illegal SHALL clear to 0, and the field outputs keep their last values.
REQ-022 With hold=1 at an edge, every output SHALL keep its value regardless of inst_valid and instIn.
REQ-023 The strobes SHALL be one-hot-or-zero: mem_rd and mem_wr are never both 1, and illegal=1 forces reg_we=0, mem_rd=0 and mem_wr=0.
REQ-024 Back-to-back valid instructions SHALL be decoded one per cycle with no bubbles.

Reset
REQ-025 While rst=1, every output SHALL be 0 immediately, independent of clk.
REQ-026 A reset asserted mid-stream SHALL discard the instruction in flight, and the first valid instruction after release decodes normally.

Structure
REQ-027 Package cu_pkg SHALL hold the opcode enum, the field width constants (OPW=4, REGW=3, ADRW=4, INSTW=13) and the field bit-position constants.
REQ-028 The combinational decode SHALL be a sub-module cu_decode (instIn in, unregistered fields and strobes out), and cu SHALL own the output registers and the hold/valid/reset logic.

Verification
REQ-029 Scenario: instIn=0001001010011, valid -> next cycle opcode=0001, operanda=001, operandb=010, dest=011, reg_we=1, alu_op=0001, out_valid=1.
REQ-030 Scenario: instIn=1111110000101 -> opcode=1111, adrr=1100, dest=101, mem_wr=1, reg_we=0, operanda=000, operandb=000.
REQ-031 Scenario: instIn=1110010000100 -> opcode=1110, adrr=0100, dest=100, mem_rd=1, reg_we=1.
REQ-032 Scenario: back-to-back 0011001011100 then 1001011111000 -> consecutive cycles give (0011, 001, 011, 100) then (1001, 011, 111, 000), both reg_we=1.
REQ-033 Scenario: instIn=1011000000000 -> illegal=1, all strobes 0; then hold=1 with a new valid input -> outputs unchanged.
REQ-034 Scenario: rst pulsed between clock edges after a valid ADD -> all outputs 0 immediately; instIn=0000000000000 after release -> NOP with out_valid=1, reg_we=0.
